dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter that shares the single data-memory port of `sccomp` between the CPU load/store unit (master 0) and a debug/loader master (master 1). The debug/loader master preloads data memory and inspects it at run time in place of simulator file loads. It sits between `U_SCPU`'s data-memory outputs and `U_DM`, tracks which master owns each in-flight read, and supports an exclusive lock so the loader can perform uninterrupted bursts.

## Interface
- `AW`, 32, address width in bits
- `DW`, 32, data width in bits; byte strobes are `DW/8` bits wide

- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `m0_req`  in  1  CPU access request
- `m0_we`  in  1  CPU write (1) / read (0)
- `m0_addr`  in  AW  CPU byte address
- `m0_wdata`  in  DW  CPU write data
- `m0_wstrb`  in  DW/8  CPU byte enables
- `m0_gnt`  out  1  CPU request accepted this cycle
- `m0_rvalid`  out  1  CPU read data valid
- `m0_rdata`  out  DW  CPU read data
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_wstrb`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: same directions, widths and meanings for the debug/loader master
- `m1_lock`  in  1  loader requests exclusive ownership
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  DW/8  byte write enables; all zero for a read
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid one cycle after `mem_en` for a read

## Operation
- States: `OPEN` (normal arbitration) and `LOCKED` (master 1 exclusive).
- `OPEN`:
  - With one requester, that master is granted.
  - With both requesting, the arbitration policy decides (see Configuration).
  - If master 1 is granted with `m1_lock`=1, the next state is `LOCKED`.
- `LOCKED`:
  - `m0_gnt` is forced to 0.
  - `m1_gnt` = `m1_req`.
  - Exit to `OPEN` on the first cycle with `m1_lock`=0. That cycle is already arbitrated as `OPEN`.
- Exactly one grant or none per cycle; the two `gnt` outputs are never high together.
- The granted master's fields drive the `mem_*` outputs. `mem_en` = any grant. `mem_we` = `wstrb` if `we` is set, else 0.
- Read ownership: a registered tag `{pend, owner}` is set on a granted read and cleared otherwise.
- The next cycle raises `rvalid` for `owner` only; `rdata` = `mem_rdata` for that owner, 0 for the other.
- Writes produce no `rvalid`.
- Back-to-back accesses are allowed every cycle, with no bubble.
- A master with `req`=0 is never granted. Its `gnt` is don't-care-free: it is held at 0.

## Timing
- `gnt` is combinational from `req`/state in the same cycle. Address and data are sampled by memory on that edge.
- Read latency: `rvalid` exactly 1 cycle after `gnt`.
- Reset values:
  - state `OPEN`, `pend`=0, RR pointer favours master 0.
  - `m0_gnt`=`m1_gnt`=0, `m0_rvalid`=`m1_rvalid`=0, `m0_rdata`=`m1_rdata`=0.
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- `rst` during a pending read drops the response: no `rvalid` the following cycle.
- `rst` while `LOCKED` returns to `OPEN`.
- `m1_lock` asserted without `m1_req`: no transition to `LOCKED`.
- CPU stalls whenever `m0_req`=1 and `m0_gnt`=0.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin.
  - On contention, the master not granted last time wins.
  - The pointer updates only on a contended grant.
- Undefined: fixed priority, master 0 (CPU) always wins contention. Master 1 then progresses only when the CPU is idle or via `LOCKED`.

## Structure
- Package `dmem_arb_pkg`:
  - state enum `ARB_OPEN`/`ARB_LOCKED`
  - master ID constants `M_CPU`=0, `M_DBG`=1
- One sub-module `arb_rr2`: a 2-way grant selector holding the RR pointer, with a compile-time fixed-priority fallback.
- The top holds the FSM, read tag and mux.

## Test plan
- Reset: assert `rst` with both `req`=1 → all outputs 0; after release, `m0_gnt`=1 first.
- CPU read alone: `m0_req`=1, `m0_addr`=0x10, mem word 0xDEADBEEF → `m0_gnt`=1 at cycle N; `m0_rvalid`=1 and `m0_rdata`=0xDEADBEEF at N+1; `m1_rvalid`=0.
- Contention, 4 cycles, both reading:
  - with `DMEM_ARB_RR_EN`, grants alternate m0,m1,m0,m1;
  - without it, m0 ×4 and m1 never.
- Lock burst: m1 writes 0x1..0x4 to 0x100..0x10C with `m1_lock`=1 while `m0_req`=1 → `m0_gnt`=0 for all 4 cycles; m0 is granted the cycle `m1_lock` drops; memory holds 0x1..0x4.
- Byte write: `m0_we`=1, `m0_wstrb`=4'b0010, `m0_wdata`=0x0000AB00 → `mem_we`=4'b0010; a following read returns only byte 1 changed.
- Reset mid-read: grant an m1 read, then `rst`=1 the next cycle → `m1_rvalid` stays 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, master IDs
// and the registered read-ownership tag.
package dmem_arb_pkg;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

  typedef struct packed {
    logic pend;
    logic owner;
  } rd_tag_t;

  function automatic logic is_owner(
    input rd_tag_t t,
    input logic    id
  );
    return t.pend && (t.owner == id);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way grant selector. RR_EN=1 alternates on contention,
// RR_EN=0 gives master 0 fixed priority.
module arb_rr2 #(
  parameter bit RR_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic fav1;
  logic pick1;
  logic both;

  assign both  = req0 && req1;
  assign pick1 = RR_EN && fav1;

  assign gnt0 = en && req0 && !(req1 && pick1);
  assign gnt1 = en && req1 && !(req0 && !pick1);

  // Pointer moves only when both masters competed.
  always_ff @(posedge clk) begin
    if (rst) begin
      fav1 <= 1'b0;
    end else if (en && both) begin
      fav1 <= gnt0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between CPU (m0) and debug/loader (m1).
// Define DMEM_ARB_RR_EN for round-robin; default is CPU priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wstrb,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  input  logic            m1_lock,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic            mem_en,
  output logic [DW/8-1:0] mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

`ifdef DMEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  arb_state_t state;
  rd_tag_t    tag;

  logic hold;
  logic arb_en;
  logic a_gnt0;
  logic a_gnt1;
  logic sel_we;
  logic rd_fire;

  // A cycle with m1_lock low is arbitrated as OPEN.
  assign hold   = (state == ARB_LOCKED) && m1_lock;
  assign arb_en = !rst && !hold;

  arb_rr2 #(
    .RR_EN (RR_EN)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (arb_en),
    .req0 (m0_req),
    .req1 (m1_req),
    .gnt0 (a_gnt0),
    .gnt1 (a_gnt1)
  );

  assign m0_gnt = a_gnt0;
  assign m1_gnt = a_gnt1 || (!rst && hold && m1_req);
  assign mem_en = m0_gnt || m1_gnt;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = '0;
    sel_we    = 1'b0;
    unique case (1'b1)
      m1_gnt: begin
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_we    = m1_we ? m1_wstrb : '0;
        sel_we    = m1_we;
      end
      m0_gnt: begin
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_we    = m0_we ? m0_wstrb : '0;
        sel_we    = m0_we;
      end
      default: ;
    endcase
  end

  assign rd_fire = mem_en && !sel_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_OPEN;
      tag   <= '0;
    end else begin
      if (hold || (m1_gnt && m1_lock)) begin
        state <= ARB_LOCKED;
      end else begin
        state <= ARB_OPEN;
      end
      tag.pend  <= rd_fire;
      tag.owner <= m1_gnt ? M_DBG : M_CPU;
    end
  end

  assign m0_rvalid = !rst && is_owner(tag, M_CPU);
  assign m1_rvalid = !rst && is_owner(tag, M_DBG);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter with a byte-strobed
// memory model; expectations follow DMEM_ARB_RR_EN when defined.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_wstrb  (m0_wstrb),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wstrb  (m1_wstrb),
    .m1_lock   (m1_lock),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (rst) begin
      mem[4] <= 32'hDEADBEEF;
      mem[8] <= 32'h11223344;
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr[9:2]];
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic [3:0]  s0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic [3:0]  s1;
    logic        lk;
    logic        g0, g1;
    logic [3:0]  we;
    logic [31:0] ma, md;
    logic        v0;
    logic [31:0] rd0;
    logic        v1;
    logic [31:0] rd1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(
    input logic r0, input logic w0, input logic [31:0] a0,
    input logic [31:0] d0, input logic [3:0] s0,
    input logic r1, input logic w1, input logic [31:0] a1,
    input logic [31:0] d1, input logic [3:0] s1, input logic lk,
    input logic g0, input logic g1, input logic [3:0] we,
    input logic [31:0] ma, input logic [31:0] md,
    input logic v0, input logic [31:0] rd0,
    input logic v1, input logic [31:0] rd1
  );
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.s0 = s0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.s1 = s1;
    v.lk = lk; v.g0 = g0; v.g1 = g1; v.we = we; v.ma = ma;
    v.md = md; v.v0 = v0; v.rd0 = rd0; v.v1 = v1; v.rd1 = rd1;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0;
    m0_wdata = v.d0; m0_wstrb = v.s0;
    m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1;
    m1_wdata = v.d1; m1_wstrb = v.s1; m1_lock = v.lk;
  endtask

  task automatic set_idle();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    m1_lock = 0;
  endtask

  localparam logic [31:0] BEEF = 32'hDEADBEEF;
  localparam logic [31:0] W20  = 32'h11223344;

  initial begin
    set_idle();
    rst = 1'b1;

    // Contention from reset
`ifdef DMEM_ARB_RR_EN
    add(1,0,32'h10,0,0, 1,0,32'h20,0,0, 0, 1,0,0,32'h10,0, 0,0,    0,0);
    add(1,0,32'h10,0,0, 1,0,32'h20,0,0, 0, 0,1,0,32'h20,0, 1,BEEF, 0,0);
    add(1,0,32'h10,0,0, 1,0,32'h20,0,0, 0, 1,0,0,32'h10,0, 0,0,    1,W20);
    add(1,0,32'h10,0,0, 1,0,32'h20,0,0, 0, 0,1,0,32'h20,0, 1,BEEF, 0,0);
    add(1,0,32'h10,0,0, 0,0,0,0,0,      0, 1,0,0,32'h10,0, 0,0,    1,W20);
`else
    add(1,0,32'h10,0,0, 1,0,32'h20,0,0, 0, 1,0,0,32'h10,0, 0,0,    0,0);
    add(1,0,32'h10,0,0, 1,0,32'h20,0,0, 0, 1,0,0,32'h10,0, 1,BEEF, 0,0);
    add(1,0,32'h10,0,0, 1,0,32'h20,0,0, 0, 1,0,0,32'h10,0, 1,BEEF, 0,0);
    add(1,0,32'h10,0,0, 1,0,32'h20,0,0, 0, 1,0,0,32'h10,0, 1,BEEF, 0,0);
    add(1,0,32'h10,0,0, 0,0,0,0,0,      0, 1,0,0,32'h10,0, 1,BEEF, 0,0);
`endif
    add(0,0,0,0,0,      0,0,0,0,0,      0, 0,0,0,0,0,      1,BEEF, 0,0);
    // Lock burst
    add(0,0,0,0,0,      1,1,32'h100,1,4'hf, 1, 0,1,4'hf,32'h100,1, 0,0, 0,0);
    add(1,0,32'h10,0,0, 1,1,32'h104,2,4'hf, 1, 0,1,4'hf,32'h104,2, 0,0, 0,0);
    add(1,0,32'h10,0,0, 1,1,32'h108,3,4'hf, 1, 0,1,4'hf,32'h108,3, 0,0, 0,0);
    add(1,0,32'h10,0,0, 1,1,32'h10C,4,4'hf, 1, 0,1,4'hf,32'h10C,4, 0,0, 0,0);
    add(1,0,32'h10,0,0, 0,0,0,0,0,      0, 1,0,0,32'h10,0,  0,0,    0,0);
    add(1,0,32'h100,0,0, 0,0,0,0,0,     0, 1,0,0,32'h100,0, 1,BEEF, 0,0);
    add(1,0,32'h104,0,0, 0,0,0,0,0,     0, 1,0,0,32'h104,0, 1,1,    0,0);
    add(1,0,32'h108,0,0, 0,0,0,0,0,     0, 1,0,0,32'h108,0, 1,2,    0,0);
    add(1,0,32'h10C,0,0, 0,0,0,0,0,     0, 1,0,0,32'h10C,0, 1,3,    0,0);
    add(0,0,0,0,0,      0,0,0,0,0,      0, 0,0,0,0,0,       1,4,    0,0);
    // Byte write then read back
    add(1,1,32'h20,32'h0000AB00,4'b0010, 0,0,0,0,0, 0,
        1,0,4'b0010,32'h20,32'h0000AB00, 0,0, 0,0);
    add(1,0,32'h20,0,0, 0,0,0,0,0,      0, 1,0,0,32'h20,0,  0,0,    0,0);
    add(0,0,0,0,0,      0,0,0,0,0,      0, 0,0,0,0,0,  1,32'h1122AB44, 0,0);
    // Lock without request never locks
    add(1,0,32'h10,0,0, 0,0,0,0,0,      1, 1,0,0,32'h10,0,  0,0,    0,0);
    add(1,0,32'h10,0,0, 0,0,0,0,0,      1, 1,0,0,32'h10,0,  1,BEEF, 0,0);
    // Loader read alone
    add(0,0,0,0,0,      1,0,32'h100,0,0, 0, 0,1,0,32'h100,0, 1,BEEF, 0,0);
    add(0,0,0,0,0,      0,0,0,0,0,      0, 0,0,0,0,0,       0,0,    1,1);

    // Reset with both masters requesting
    @(negedge clk);
    m0_req = 1; m1_req = 1; m0_addr = 32'h10; m1_addr = 32'h20;
    m0_wdata = 32'h55; m1_wdata = 32'h66;
    @(negedge clk);
    #1;
    chk("rst_m0_gnt", {31'd0, m0_gnt}, 0);
    chk("rst_m1_gnt", {31'd0, m1_gnt}, 0);
    chk("rst_mem_en", {31'd0, mem_en}, 0);
    chk("rst_mem_we", {28'd0, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 0);
    chk("rst_rdata", m0_rdata | m1_rdata, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = 1'b0;
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_m0_gnt", i), {31'd0, m0_gnt}, {31'd0, vecs[i].g0});
      chk($sformatf("v%0d_m1_gnt", i), {31'd0, m1_gnt}, {31'd0, vecs[i].g1});
      chk($sformatf("v%0d_mem_en", i), {31'd0, mem_en},
          {31'd0, vecs[i].g0 | vecs[i].g1});
      chk($sformatf("v%0d_mem_we", i), {28'd0, mem_we}, {28'd0, vecs[i].we});
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].ma);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].md);
      chk($sformatf("v%0d_m0_rvalid", i), {31'd0, m0_rvalid}, {31'd0, vecs[i].v0});
      chk($sformatf("v%0d_m0_rdata", i), m0_rdata, vecs[i].rd0);
      chk($sformatf("v%0d_m1_rvalid", i), {31'd0, m1_rvalid}, {31'd0, vecs[i].v1});
      chk($sformatf("v%0d_m1_rdata", i), m1_rdata, vecs[i].rd1);
    end

    // Reset mid-read drops the loader response
    @(negedge clk);
    set_idle();
    m1_req = 1; m1_addr = 32'h10;
    #1;
    chk("mr_m1_gnt", {31'd0, m1_gnt}, 1);
    @(negedge clk);
    rst = 1'b1; m1_req = 0;
    #1;
    chk("mr_rst_m1_rvalid", {31'd0, m1_rvalid}, 0);
    chk("mr_rst_m1_rdata", m1_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_post_m1_rvalid", {31'd0, m1_rvalid}, 0);

    // Reset while locked returns to OPEN
    @(negedge clk);
    m1_req = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'h9;
    m1_wstrb = 4'hf; m1_lock = 1;
    #1;
    chk("lr_m1_gnt", {31'd0, m1_gnt}, 1);
    @(negedge clk);
    rst = 1'b1; m0_req = 1; m0_addr = 32'h10;
    #1;
    chk("lr_rst_gnt", {30'd0, m0_gnt, m1_gnt}, 0);
    chk("lr_rst_mem_en", {31'd0, mem_en}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("lr_open_m0_gnt", {31'd0, m0_gnt}, 1);
    chk("lr_open_m1_gnt", {31'd0, m1_gnt}, 0);

    @(negedge clk);
    set_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
